beat_pingpong_buffer: RTL and testbench

BEAT_PINGPONG_BUFFER -- requirements
Module: beat_pingpong_buffer

---
 rtl/beat_pingpong_buffer.sv | 126 ++++++++++++
 tb/tb_beat_pingpong_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_pingpong_buffer.sv
// Double-buffered beatmap store: a writer fills the back bank while a paced
// reader plays the front bank; the banks exchange once the back bank is full.
module beat_pingpong_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DIV    = 50,
  parameter int LOOP   = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              underrun,
  output logic              swap,
  output logic              bank_sel
);

  localparam int                CNT_W   = $clog2(DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);

  // Both banks share one array; the MSB of the index is the bank number.
  logic [DATA_W-1:0] mem_q [2*DEPTH];

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bank_sel_q, bank_sel_d;
  logic              front_valid_q, front_valid_d;
  logic              back_full_q, back_full_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              underrun_q, underrun_d;
  logic              swap_q, swap_d;

  logic tick, wr_en, rd_en, swap_en;

  always_comb begin
    tick    = (cnt_q == CNT_MAX);
    wr_en   = wr_valid && !back_full_q;
    rd_en   = tick && front_valid_q;
    swap_en = back_full_q && !front_valid_q;

    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    bank_sel_d    = bank_sel_q;
    front_valid_d = front_valid_q;
    back_full_d   = back_full_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    underrun_d    = tick && !front_valid_q;
    swap_d        = swap_en;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_q == PTR_MAX) begin
        back_full_d = 1'b1;
        wr_ptr_d    = '0;
      end
    end

    if (rd_en) begin
      rd_data_d  = mem_q[{bank_sel_q, rd_ptr_q}];
      rd_valid_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + 1'b1;
      // In loop mode the front bank keeps replaying until a new frame is ready.
      if (rd_ptr_q == PTR_MAX && (LOOP == 0 || back_full_q))
        front_valid_d = 1'b0;
    end

    // rd_en and swap_en are mutually exclusive via front_valid; wr_en and
    // swap_en via back_full, so the swap overrides nothing in flight.
    if (swap_en) begin
      bank_sel_d    = !bank_sel_q;
      front_valid_d = 1'b1;
      back_full_d   = 1'b0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q         <= '0;
      bank_sel_q    <= 1'b0;
      front_valid_q <= 1'b0;
      back_full_q   <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      underrun_q    <= 1'b0;
      swap_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      bank_sel_q    <= bank_sel_d;
      front_valid_q <= front_valid_d;
      back_full_q   <= back_full_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      underrun_q    <= underrun_d;
      swap_q        <= swap_d;
    end
  end

  // Storage is deliberately not reset; only flags and pointers are.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[{!bank_sel_q, wr_ptr_q}] <= wr_data;
  end

  assign wr_ready = !back_full_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign underrun = underrun_q;
  assign swap     = swap_q;
  assign bank_sel = bank_sel_q;

endmodule

// File: tb/tb_beat_pingpong_buffer.sv
// Directed bench for beat_pingpong_buffer (DEPTH=4, DIV=3): one instance with
// LOOP=0 and one with LOOP=1, checked against hand-computed read sequences.
module tb_beat_pingpong_buffer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wr_valid = 1'b0, wr_valid_l = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, rd_valid, underrun, swap, bank_sel;
  logic [7:0] rd_data;
  logic       wr_ready_l, rd_valid_l, underrun_l, swap_l, bank_sel_l;
  logic [7:0] rd_data_l;

  int checks = 0, fails = 0, wr_timeouts = 0;
  int ur_cnt = 0, sw_cnt = 0, ur_cntl = 0, sw_cntl = 0;
  logic [7:0] rd_q[$], rd_ql[$];

  always #5 clk = ~clk;

  beat_pingpong_buffer #(.DATA_W(8), .DEPTH(4), .ADDR_W(2), .DIV(3), .LOOP(0)) dut (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .underrun(underrun), .swap(swap), .bank_sel(bank_sel));

  beat_pingpong_buffer #(.DATA_W(8), .DEPTH(4), .ADDR_W(2), .DIV(3), .LOOP(1)) dut_l (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid_l), .wr_data(wr_data),
    .wr_ready(wr_ready_l), .rd_data(rd_data_l), .rd_valid(rd_valid_l),
    .underrun(underrun_l), .swap(swap_l), .bank_sel(bank_sel_l));

  // Output log, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rd_valid) rd_q.push_back(rd_data);
    if (underrun) ur_cnt++;
    if (swap) sw_cnt++;
    if (rd_valid_l) rd_ql.push_back(rd_data_l);
    if (underrun_l) ur_cntl++;
    if (swap_l) sw_cntl++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic clear_logs();
    rd_q.delete(); rd_ql.delete();
    ur_cnt = 0; sw_cnt = 0; ur_cntl = 0; sw_cntl = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; wr_valid = 1'b0; wr_valid_l = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    clear_logs();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic write_word(input bit lp, input logic [7:0] d);
    int unsigned n;
    n = 0;
    wr_data = d;
    if (lp) wr_valid_l = 1'b1; else wr_valid = 1'b1;
    while (!(lp ? wr_ready_l : wr_ready) && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) wr_timeouts++;
    @(negedge clk);
    wr_valid = 1'b0; wr_valid_l = 1'b0;
  endtask

  task automatic wait_reads(input bit lp, input int n);
    int unsigned c;
    c = 0;
    while ((lp ? rd_ql.size() : rd_q.size()) < n && c < 400) begin
      @(negedge clk); c++;
    end
  endtask

  task automatic test_reset();
    int last, first, nur, gapbad, bad;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_data, rd_valid, underrun, swap, bank_sel, wr_ready} !== 13'h0001) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h",
               {rd_data, rd_valid, underrun, swap, bank_sel, wr_ready}, 13'h0001);
    end
    resetn = 1'b1;
    clear_logs();
    last = -1; first = -1; nur = 0; gapbad = 0; bad = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (underrun) begin
        if (first < 0) first = i;
        if (last >= 0 && i - last != 3) gapbad++;
        last = i; nur++;
      end
      if (rd_valid || rd_data !== 8'h00 || wr_ready !== 1'b1) bad++;
    end
    checks++;
    if (nur !== 4) begin fails++; $display("FAIL idle_underrun_count: got %0d expected 4", nur); end
    checks++;
    if (first !== 3) begin fails++; $display("FAIL idle_first_underrun: got cycle %0d expected 3", first); end
    checks++;
    if (gapbad !== 0) begin fails++; $display("FAIL idle_underrun_period: got %0d bad gaps expected 0", gapbad); end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL idle_outputs: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_fill();
    clear_logs();
    for (int i = 0; i < 4; i++) write_word(1'b0, 8'h11 * (i + 1));
    checks++;
    if (wr_ready !== 1'b0) begin fails++; $display("FAIL fill_wr_ready_low: got %b expected 0", wr_ready); end
    @(negedge clk);
    checks++;
    if ({swap, bank_sel, wr_ready} !== 3'b111) begin
      fails++; $display("FAIL fill_swap: got %b expected 111", {swap, bank_sel, wr_ready});
    end
  endtask

  task automatic test_play();
    logic [7:0] exp_v;
    for (int i = 0; i < 4; i++) write_word(1'b0, 8'h55 + 8'h11 * i);
    wait_reads(1'b0, 1);
    ur_cnt = 0;
    wait_reads(1'b0, 8);
    checks++;
    if (rd_q.size() !== 8) begin fails++; $display("FAIL play_count: got %0d expected 8", rd_q.size()); end
    for (int i = 0; i < 8 && i < rd_q.size(); i++) begin
      exp_v = 8'h11 * (i + 1);
      checks++;
      if (rd_q[i] !== exp_v) begin fails++; $display("FAIL play_data[%0d]: got %h expected %h", i, rd_q[i], exp_v); end
    end
    checks++;
    if (ur_cnt !== 0) begin fails++; $display("FAIL play_no_underrun: got %0d expected 0", ur_cnt); end
    checks++;
    if (bank_sel !== 1'b0 || sw_cnt !== 2) begin
      fails++; $display("FAIL play_second_swap: got bank_sel %b swaps %0d expected 0 and 2", bank_sel, sw_cnt);
    end
    repeat (7) @(negedge clk);
    checks++;
    if (ur_cnt == 0 || rd_q.size() !== 8) begin
      fails++; $display("FAIL play_drain: got underruns %0d reads %0d expected >0 and 8", ur_cnt, rd_q.size());
    end
    checks++;
    if (wr_timeouts !== 0) begin fails++; $display("FAIL play_wr_timeout: got %0d expected 0", wr_timeouts); end
  endtask

  task automatic test_loop();
    logic [7:0] exp_v;
    int k, nonA;
    int unsigned c;
    do_reset();
    for (int i = 0; i < 4; i++) write_word(1'b1, 8'hA0 + 8'(i));
    wait_reads(1'b1, 1);
    ur_cntl = 0;
    wait_reads(1'b1, 10);
    checks++;
    if (rd_ql.size() < 10) begin fails++; $display("FAIL loop_count: got %0d expected 10", rd_ql.size()); end
    for (int i = 0; i < 10 && i < rd_ql.size(); i++) begin
      exp_v = 8'hA0 + 8'(i % 4);
      checks++;
      if (rd_ql[i] !== exp_v) begin fails++; $display("FAIL loop_data[%0d]: got %h expected %h", i, rd_ql[i], exp_v); end
    end
    rd_ql.delete();
    for (int i = 0; i < 4; i++) write_word(1'b1, 8'hB0 + 8'(i));
    c = 0;
    while (!(rd_ql.size() > 0 && rd_ql[rd_ql.size()-1] == 8'hB3) && c < 400) begin
      @(negedge clk); c++;
    end
    k = -1; nonA = 0;
    for (int i = 0; i < rd_ql.size(); i++) begin
      if (k < 0 && rd_ql[i][7:4] == 4'hB) k = i;
      if (k < 0 && rd_ql[i][7:4] != 4'hA) nonA++;
    end
    checks++;
    if (k < 1 || nonA != 0 || rd_ql[k-1] !== 8'hA3) begin
      fails++; $display("FAIL loop_swap_after_A3: got first B at %0d, foreign words %0d, expected A3 before B0", k, nonA);
    end
    checks++;
    if (k < 0 || rd_ql.size() - k !== 4) begin
      fails++; $display("FAIL loop_new_frame_len: got %0d expected 4", (k < 0) ? 0 : rd_ql.size() - k);
    end
    for (int j = 0; j < 4 && k >= 0 && k + j < rd_ql.size(); j++) begin
      exp_v = 8'hB0 + 8'(j);
      checks++;
      if (rd_ql[k+j] !== exp_v) begin fails++; $display("FAIL loop_new_frame[%0d]: got %h expected %h", j, rd_ql[k+j], exp_v); end
    end
    checks++;
    if (ur_cntl !== 0 || sw_cntl !== 2) begin
      fails++; $display("FAIL loop_flags: got underruns %0d swaps %0d expected 0 and 2", ur_cntl, sw_cntl);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD5, 8'hD6, 8'hD7, 8'hD8};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      wr_data = 8'hD0 + 8'(i);
      wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wait_reads(1'b0, 8);
    repeat (6) @(negedge clk);
    checks++;
    if (rd_q.size() !== 8) begin fails++; $display("FAIL overflow_count: got %0d expected 8", rd_q.size()); end
    for (int i = 0; i < 8 && i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== exp_tab[i]) begin fails++; $display("FAIL overflow_data[%0d]: got %h expected %h", i, rd_q[i], exp_tab[i]); end
    end
  endtask

  task automatic test_reset_mid();
    write_word(1'b0, 8'h99);
    write_word(1'b0, 8'h9A);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({rd_data, rd_valid, underrun, swap, bank_sel, wr_ready} !== 13'h0001) begin
      fails++;
      $display("FAIL midreset_outputs: got %h expected %h",
               {rd_data, rd_valid, underrun, swap, bank_sel, wr_ready}, 13'h0001);
    end
    @(negedge clk);
    resetn = 1'b1;
    clear_logs();
    for (int i = 0; i < 4; i++) write_word(1'b0, 8'hC0 + 8'(i));
    wait_reads(1'b0, 4);
    checks++;
    if (rd_q.size() < 4) begin fails++; $display("FAIL midreset_count: got %0d expected 4", rd_q.size()); end
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== 8'hC0 + 8'(i)) begin
        fails++; $display("FAIL midreset_data[%0d]: got %h expected %h", i, rd_q[i], 8'hC0 + 8'(i));
      end
    end
    checks++;
    if (wr_timeouts !== 0) begin fails++; $display("FAIL write_timeouts: got %0d expected 0", wr_timeouts); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_play();
    test_loop();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
